// File: rtl/alu4_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu4_acc_seq
// Description : Command sequencer and 4-bit accumulator wrapped around an
//               external combinational 4-bit ALU. A command is accepted over
//               a valid/ready handshake. It is executed against the
//               accumulator, which is ALU operand a, with the command data as
//               operand b. The new accumulator value is then offered
//               downstream over a second valid/ready handshake.
//
// Parameters  : CNT_W   - width of the completed-operation counter (wraps)
//               ACC_RST - accumulator value after reset
//
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               in_valid/in_ready - command handshake
//               in_load           - 1: load in_data, 0: take ALU result
//               in_opt, in_data   - ALU opcode, operand b / load value
//               alu_a/b/opt       - registered operands to the ALU
//               alu_y             - ALU combinational result
//               out_valid/ready   - result handshake
//               out_data/out_zero - new accumulator value and its zero flag
//               op_cnt            - count of results handed downstream
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu4_acc_seq #(
    parameter int         CNT_W   = 8,
    parameter logic [3:0] ACC_RST = 4'h0
) (
    input  logic             clk,
    input  logic             rst,
    // command side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_load,
    input  logic [2:0]       in_opt,
    input  logic [3:0]       in_data,
    // ALU side
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_opt,
    input  logic [3:0]       alu_y,
    // result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // The zero flag comes out of reset set when the accumulator resets to 0.
    localparam logic             c_ZERO_RST = (ACC_RST == 4'h0);

    state_t           r_state;
    logic [3:0]       r_acc;
    logic [3:0]       r_b;
    logic [2:0]       r_opt;
    logic             r_load;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [3:0]       r_out_data;
    logic             r_out_zero;
    logic [CNT_W-1:0] r_op_cnt;

    // The value written back in EXEC. The ALU has had a full cycle to settle
    // on the registered operands, so alu_y is stable at this edge.
    logic [3:0]       w_result;
    assign w_result = r_load ? r_b : alu_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= ACC_RST;
            r_b         <= 4'h0;
            r_opt       <= 3'b000;
            r_load      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 4'h0;
            r_out_zero  <= c_ZERO_RST;
            r_op_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_b        <= in_data;
                        r_opt      <= in_opt;
                        r_load     <= in_load;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    r_acc       <= w_result;
                    r_out_data  <= w_result;
                    r_out_zero  <= (w_result == 4'h0);
                    r_out_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end

                ST_RESP: begin
                    // Result and flag are held until downstream takes them.
                    // Any command presented now waits upstream.
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_op_cnt    <= r_op_cnt + c_CNT_ONE;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign alu_a     = r_acc;
    assign alu_b     = r_b;
    assign alu_opt   = r_opt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_zero  = r_out_zero;
    assign op_cnt    = r_op_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu4_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu4_acc_seq
// Description : Directed bench for alu4_acc_seq. It provides a behavioural
//               4-bit ALU on the alu_* ports and checks hand-computed results,
//               handshake timing, backpressure, reset and counter wrap. The
//               counter is built 2 bits wide so that it wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu4_acc_seq;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_load;
    logic [2:0]       in_opt;
    logic [3:0]       in_data;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_opt;
    logic [3:0]       alu_y;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic             out_zero;
    logic [CNT_W-1:0] op_cnt;

    int n_total = 0;
    int n_bad   = 0;

    alu4_acc_seq #(.CNT_W(CNT_W), .ACC_RST(4'h0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_load   (in_load),
        .in_opt    (in_opt),
        .in_data   (in_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_opt   (alu_opt),
        .alu_y     (alu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .op_cnt    (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a,
    // 110 signed a<b, 111 a==b.
    always_comb begin
        case (alu_opt)
            3'b000:  alu_y = alu_a + alu_b;
            3'b001:  alu_y = alu_a - alu_b;
            3'b010:  alu_y = alu_a & alu_b;
            3'b011:  alu_y = alu_a | alu_b;
            3'b100:  alu_y = alu_a ^ alu_b;
            3'b101:  alu_y = ~alu_a;
            3'b110:  alu_y = {3'b000, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = {3'b000, (alu_a == alu_b)};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a command, waits for acceptance and checks that the result
    // appears after exactly one EXEC cycle. Returns at a falling edge in RESP.
    task automatic send(input logic ld, input logic [2:0] op, input logic [3:0] d);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_load  = ld;
        in_opt   = op;
        in_data  = d;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("exec_valid", out_valid, 0);
        chk("exec_ready", in_ready, 0);
        @(negedge clk);
        chk("resp_valid", out_valid, 1);
    endtask

    // Takes the result now on offer and checks it and the counter after.
    task automatic take(input logic [3:0] exp_d, input logic exp_z, input logic [CNT_W-1:0] exp_c);
        chk("out_data", out_data, exp_d);
        chk("out_zero", out_zero, exp_z);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("op_cnt", op_cnt, exp_c);
        chk("done_valid", out_valid, 0);
        chk("done_ready", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_load   = 1'b0;
        in_opt    = 3'b000;
        in_data   = 4'h0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_zero", out_zero, 1);
        chk("rst_cnt", op_cnt, 0);
        chk("rst_alu_a", alu_a, 0);
        rst = 1'b0;

        // reset during EXEC discards the command
        @(negedge clk);
        in_valid = 1'b1; in_load = 1'b1; in_opt = 3'b010; in_data = 4'h9;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("mid_alu_b", alu_b, 4'h9);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_ready", in_ready, 1);
        chk("mid_alu_a", alu_a, 0);
        chk("mid_alu_b0", alu_b, 0);
        chk("mid_alu_opt", alu_opt, 0);
        chk("mid_cnt", op_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        send(1'b0, 3'b000, 4'h3); take(4'h3, 1'b0, 2'd1);

        // load then add
        send(1'b1, 3'b000, 4'h5); take(4'h5, 1'b0, 2'd2);
        send(1'b0, 3'b000, 4'h3); take(4'h8, 1'b0, 2'd3);
        // subtract wrap 8-9 = F, then signed -1 < 2
        send(1'b0, 3'b001, 4'h9); take(4'hF, 1'b0, 2'd0);
        send(1'b0, 3'b110, 4'h2); take(4'h1, 1'b0, 2'd1);
        // equal flag, then result zero
        send(1'b1, 3'b000, 4'h6); take(4'h6, 1'b0, 2'd2);
        send(1'b0, 3'b111, 4'h6); take(4'h1, 1'b0, 2'd3);
        send(1'b0, 3'b001, 4'h1); take(4'h0, 1'b1, 2'd0);

        // backpressure: result 0+2 held while a new command waits upstream
        send(1'b0, 3'b000, 4'h2);
        in_valid = 1'b1; in_load = 1'b0; in_opt = 3'b000; in_data = 4'h4;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 4'h2);
            chk("bp_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_cnt", op_cnt, 2'd1);
        chk("bp_idle", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_accept", in_ready, 0);
        @(negedge clk);
        chk("bp_exec", out_valid, 0);
        @(negedge clk);
        chk("bp_resp", out_valid, 1);
        take(4'h6, 1'b0, 2'd2);

        // counter wrap from a fresh reset: 1,2,3,0,1
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("wrap_rst_cnt", op_cnt, 0);
        send(1'b1, 3'b000, 4'h1); take(4'h1, 1'b0, 2'd1);
        send(1'b0, 3'b000, 4'h1); take(4'h2, 1'b0, 2'd2);
        send(1'b0, 3'b000, 4'h1); take(4'h3, 1'b0, 2'd3);
        send(1'b0, 3'b000, 4'h1); take(4'h4, 1'b0, 2'd0);
        send(1'b0, 3'b001, 4'h5); take(4'hF, 1'b0, 2'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
